// File: rtl/uart_transmitter.sv
// uart_transmitter: serial transmit side of the UART link.
// Sends one byte per start/busy handshake as a start bit, 8 data bits LSB first,
// an optional parity bit and 1 or 2 stop bits. Every bit lasts OVERSAMPLE rx_clk
// cycles, so the same 16x baud clock serves both link directions.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | line high, waiting for tx_start
//   ST_START | start bit (low) on the line
//   ST_DATA  | data bit bit_idx_q on the line
//   ST_PARITY| parity bit of the latched byte on the line
//   ST_STOP  | stop bit(s) (high); the last edge ends the frame
module uart_transmitter #(
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       rx_clk,
    input  logic       reset_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_complete_del_flag,
    output logic       TXD,
    output logic       tx_busy,
    output logic       tx_complete_flag
);

    localparam int            CW       = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic          ODD_BIT  = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [2:0]    bit_idx_q;
    logic [2:0]    bit_idx_d;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic          stop_idx_q;
    logic          txd_q;
    logic          busy_q;
    logic          flag_q;
    logic          bit_end;

    // Bit-cycle counter wraps at every bit boundary; next data bit index.
    always_comb begin
        bit_end   = (cnt_q == CNT_LAST);
        cnt_d     = bit_end ? '0 : cnt_q + CW'(1);
        bit_idx_d = bit_idx_q + 3'd1;
    end

    // Frame sequencer with registered line, busy and sticky completion flag.
    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            parity_q   <= 1'b0;
            stop_idx_q <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            flag_q     <= 1'b0;
        end else begin
            // Host acknowledge; an accept or a frame end below overrides it.
            if (tx_complete_del_flag) begin
                flag_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    txd_q <= 1'b1;
                    if (tx_start) begin
                        shift_q    <= tx_data;
                        parity_q   <= (^tx_data) ^ ODD_BIT;
                        cnt_q      <= '0;
                        bit_idx_q  <= 3'd0;
                        stop_idx_q <= 1'b0;
                        txd_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        flag_q     <= 1'b0;
                        state_q    <= ST_START;
                    end
                end
                ST_START: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        txd_q   <= shift_q[0];
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        if (bit_idx_q == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                txd_q   <= parity_q;
                                state_q <= ST_PARITY;
                            end else begin
                                txd_q   <= 1'b1;
                                state_q <= ST_STOP;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_d;
                            txd_q     <= shift_q[bit_idx_d];
                        end
                    end
                end
                ST_PARITY: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        txd_q   <= 1'b1;
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        if ((STOP_BITS == 2) && !stop_idx_q) begin
                            stop_idx_q <= 1'b1;
                        end else begin
                            busy_q  <= 1'b0;
                            flag_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign TXD              = txd_q;
    assign tx_busy          = busy_q;
    assign tx_complete_flag = flag_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: three instances with different framing options.
// Requests push the expected byte into a per-instance queue; a monitor per
// instance watches tx_busy rise, pops the byte and checks the frame cycle by
// cycle against a slot model (start, data LSB first, parity, stop).
module tb_uart_transmitter;

    localparam int NU = 3;

    logic          rx_clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [NU-1:0] start_r = '0;
    logic [NU-1:0] del_r = '0;
    logic [NU-1:0] txd_w;
    logic [NU-1:0] busy_w;
    logic [NU-1:0] flag_w;
    logic [7:0]    data_r [NU];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fstart [NU];

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    always #5 rx_clk = ~rx_clk;

    // Free-running cycle count used to time frame starts.
    always @(posedge rx_clk) cyc <= cyc + 1;

    uart_transmitter #(.OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .rx_clk(rx_clk), .reset_n(reset_n), .tx_start(start_r[0]), .tx_data(data_r[0]),
        .tx_complete_del_flag(del_r[0]), .TXD(txd_w[0]), .tx_busy(busy_w[0]),
        .tx_complete_flag(flag_w[0]));

    uart_transmitter #(.OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
        .rx_clk(rx_clk), .reset_n(reset_n), .tx_start(start_r[1]), .tx_data(data_r[1]),
        .tx_complete_del_flag(del_r[1]), .TXD(txd_w[1]), .tx_busy(busy_w[1]),
        .tx_complete_flag(flag_w[1]));

    uart_transmitter #(.OVERSAMPLE(3), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
        .rx_clk(rx_clk), .reset_n(reset_n), .tx_start(start_r[2]), .tx_data(data_r[2]),
        .tx_complete_del_flag(del_r[2]), .TXD(txd_w[2]), .tx_busy(busy_w[2]),
        .tx_complete_flag(flag_w[2]));

    function automatic int os_of(input int u);
        return (u == 2) ? 3 : 16;
    endfunction

    function automatic int par_of(input int u);
        return (u == 0) ? 0 : 1;
    endfunction

    function automatic int odd_of(input int u);
        return (u == 2) ? 1 : 0;
    endfunction

    function automatic int stops_of(input int u);
        return (u == 1) ? 2 : 1;
    endfunction

    function automatic int flen_of(input int u);
        return (1 + 8 + par_of(u) + stops_of(u)) * os_of(u);
    endfunction

    // Line level during bit slot 'slot' of a frame carrying byte b.
    function automatic logic exp_bit(input int u, input logic [7:0] b, input int slot);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        if (par_of(u) != 0 && slot == 9) return (^b) ^ (odd_of(u) != 0);
        return 1'b1;
    endfunction

    task automatic check1(input string name, input int u, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s u%0d: got %b expected %b (cycle %0d)", name, u, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int u, input logic [7:0] b);
        case (u)
            0: q0.push_back(b);
            1: q1.push_back(b);
            default: q2.push_back(b);
        endcase
    endtask

    task automatic pop_exp(input int u, output logic [7:0] b, output bit ok);
        ok = 1'b0;
        b  = 8'h00;
        case (u)
            0: if (q0.size() > 0) begin b = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin b = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin b = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic mon(input int u);
        logic       prev;
        logic [7:0] b;
        bit         have;
        bit         bad;
        bit         aborted;
        int         badn;
        logic       badv;
        logic       badb;
        logic       expv;
        logic       badexp;
        int         f;
        int         os;
        prev = 1'b0;
        f    = flen_of(u);
        os   = os_of(u);
        forever begin
            @(negedge rx_clk);
            if (reset_n !== 1'b1) begin
                prev = 1'b0;
            end else if (busy_w[u] && !prev) begin
                fstart[u] = cyc;
                pop_exp(u, b, have);
                checks++;
                if (!have) begin
                    errors++;
                    $display("FAIL unexpected_frame u%0d: frame started at cycle %0d, expected no frame", u, cyc);
                end
                check1("accept_clears_flag", u, flag_w[u], 1'b0);
                bad = 1'b0; aborted = 1'b0; badn = 0; badv = 1'b0; badb = 1'b0; badexp = 1'b0;
                for (int n = 0; n < f; n++) begin
                    if (n > 0) @(negedge rx_clk);
                    if (reset_n !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    expv = exp_bit(u, b, n / os);
                    if (!bad && (txd_w[u] !== expv || busy_w[u] !== 1'b1)) begin
                        bad = 1'b1; badn = n; badv = txd_w[u]; badb = busy_w[u]; badexp = expv;
                    end
                end
                if (!aborted) begin
                    checks++;
                    if (bad) begin
                        errors++;
                        $display("FAIL frame_bits u%0d byte %h: at frame cycle %0d TXD=%b busy=%b, expected TXD=%b busy=1",
                                 u, b, badn, badv, badb, badexp);
                    end
                    @(negedge rx_clk);
                    if (reset_n === 1'b1) begin
                        check1("end_busy", u, busy_w[u], 1'b0);
                        check1("end_flag", u, flag_w[u], 1'b1);
                        check1("end_txd", u, txd_w[u], 1'b1);
                    end
                end
                prev = 1'b0;
            end else begin
                if (!busy_w[u]) check1("idle_txd", u, txd_w[u], 1'b1);
                prev = busy_w[u];
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge rx_clk);
        #1;
    endtask

    task automatic wait_busy(input int u, input logic v, input int lim);
        int k = 0;
        while (busy_w[u] !== v && k < lim) begin
            tick(1);
            k++;
        end
        if (busy_w[u] !== v) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout u%0d: busy=%b after %0d cycles, expected %b", u, busy_w[u], lim, v);
        end
    endtask

    // Request a frame; returns 1 time unit after the accepting edge.
    task automatic send(input int u, input logic [7:0] b);
        wait_busy(u, 1'b0, 2000);
        start_r[u] = 1'b1;
        data_r[u]  = b;
        push_exp(u, b);
        tick(1);
        start_r[u] = 1'b0;
        data_r[u]  = 8'($urandom);
    endtask

    initial begin
        fork
            mon(0);
            mon(1);
            mon(2);
        join
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s1;
        int s2;
        for (int u = 0; u < NU; u++) begin
            data_r[u] = 8'h00;
            fstart[u] = 0;
        end
        #1 reset_n = 1'b0;
        #3;
        for (int u = 0; u < NU; u++) begin
            check1("reset_txd", u, txd_w[u], 1'b1);
            check1("reset_busy", u, busy_w[u], 1'b0);
            check1("reset_flag", u, flag_w[u], 1'b0);
        end
        tick(3);
        reset_n = 1'b1;
        tick(2);

        // Parity even, two stop bits.
        send(1, 8'hA5);
        for (int i = 0; i < 10; i++) begin
            wait_busy(1, 1'b0, 400);
            tick($urandom_range(0, 3));
            send(1, 8'($urandom));
        end
        wait_busy(1, 1'b0, 400);

        // Odd parity, 3x oversampling.
        for (int i = 0; i < 30; i++) begin
            send(2, 8'($urandom));
            wait_busy(2, 1'b0, 100);
            tick($urandom_range(0, 2));
        end

        // Default framing.
        send(0, 8'h55);
        wait_busy(0, 1'b0, 400);
        tick(2);

        // Request during busy is dropped.
        send(0, 8'h0F);
        tick(49);
        start_r[0] = 1'b1;
        data_r[0]  = 8'hFF;
        tick(1);
        start_r[0] = 1'b0;
        wait_busy(0, 1'b0, 400);
        tick(5);

        // Sticky flag and acknowledge.
        send(0, 8'h3C);
        wait_busy(0, 1'b0, 400);
        for (int i = 0; i < 20; i++) begin
            check1("flag_sticky", 0, flag_w[0], 1'b1);
            tick(1);
        end
        del_r[0] = 1'b1;
        tick(1);
        del_r[0] = 1'b0;
        check1("del_clears_flag", 0, flag_w[0], 1'b0);

        // Acknowledge coinciding with the set edge.
        send(0, 8'hC3);
        tick(flen_of(0) - 1);
        del_r[0] = 1'b1;
        tick(1);
        del_r[0] = 1'b0;
        check1("set_wins_over_del", 0, flag_w[0], 1'b1);
        tick(1);
        check1("flag_held_after_set", 0, flag_w[0], 1'b1);

        // Start and acknowledge together in idle.
        start_r[0] = 1'b1;
        del_r[0]   = 1'b1;
        data_r[0]  = 8'h5A;
        push_exp(0, 8'h5A);
        tick(1);
        start_r[0] = 1'b0;
        del_r[0]   = 1'b0;
        check1("start_del_flag", 0, flag_w[0], 1'b0);
        check1("start_del_busy", 0, busy_w[0], 1'b1);
        wait_busy(0, 1'b0, 400);
        tick(3);

        // Asynchronous reset mid-frame.
        send(0, 8'h81);
        tick(70);
        #1 reset_n = 1'b0;
        #1;
        check1("abort_txd", 0, txd_w[0], 1'b1);
        check1("abort_busy", 0, busy_w[0], 1'b0);
        check1("abort_flag", 0, flag_w[0], 1'b0);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        send(0, 8'h81);
        wait_busy(0, 1'b0, 400);
        tick(3);

        // Back-to-back with tx_start held high.
        start_r[0] = 1'b1;
        data_r[0]  = 8'h12;
        push_exp(0, 8'h12);
        tick(1);
        data_r[0] = 8'h34;
        push_exp(0, 8'h34);
        wait_busy(0, 1'b0, 400);
        s1 = fstart[0];
        tick(1);
        check1("b2b_accept", 0, busy_w[0], 1'b1);
        start_r[0] = 1'b0;
        tick(1);
        s2 = fstart[0];
        check_int("b2b_gap", s2 - s1, flen_of(0) + 1);
        wait_busy(0, 1'b0, 400);

        // Random traffic with random gaps.
        for (int i = 0; i < 15; i++) begin
            tick($urandom_range(0, 4));
            send(0, 8'($urandom));
            wait_busy(0, 1'b0, 400);
        end

        tick(5);
        check_int("queue0_empty", q0.size(), 0);
        check_int("queue1_empty", q1.size(), 0);
        check_int("queue2_empty", q2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmit side of the UART link. It takes one byte over a start/busy handshake and shifts it out on `TXD` as an asynchronous frame: start bit, data bits LSB first, optional parity, and stop bit(s). Each bit lasts a fixed number of `rx_clk` cycles. The block shares the 16x oversampling clock and the complete/delete flag handshake style used by the receive path, so one baud generator drives both directions.

## Interface
Parameters:
- `OVERSAMPLE`, default 16: `rx_clk` cycles per serial bit. Legal range 2..256.
- `PARITY_EN`, default 0: 1 inserts a parity bit after data bit 7.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.

Ports:
- `rx_clk` in 1: bit-rate x `OVERSAMPLE` clock. All logic is on its rising edge.
- `reset_n` in 1: reset, asynchronous, active-low; clock `rx_clk`.
- `tx_start` in 1: request to send `tx_data`. Sampled only when `tx_busy`=0.
- `tx_data` in 8: byte to send. Captured on the accepting edge.
- `tx_complete_del_flag` in 1: host acknowledge; clears `tx_complete_flag`.
- `TXD` out 1: serial line, registered, idles high.
- `tx_busy` out 1: high from the accepting edge until the frame ends.
- `tx_complete_flag` out 1: sticky frame-done indication.

## Operation
- Reset values: `TXD`=1, `tx_busy`=0, `tx_complete_flag`=0, state IDLE, bit-cycle counter 0, bit index 0, shift register 0x00. Reset is asynchronous, so it aborts any frame in flight and `TXD` returns high immediately.
- States:
  - IDLE: `TXD`=1. On `tx_start`=1, latch `tx_data` into the shift register, compute parity, clear the counters, drive `TXD`=0, set `tx_busy`=1, clear `tx_complete_flag`, go to START.
  - START: hold 0 for `OVERSAMPLE` cycles, then go to DATA.
  - DATA: send bits 0..7, `OVERSAMPLE` cycles each. After bit 7, go to PARITY if `PARITY_EN`=1, else STOP.
  - PARITY: send ^data for even, ~^data for odd, for `OVERSAMPLE` cycles, then go to STOP.
  - STOP: `TXD`=1 for `STOP_BITS`x`OVERSAMPLE` cycles. On the final edge: go to IDLE, set `tx_busy`=0 and `tx_complete_flag`=1.
- Bit-cycle counter: counts 0..`OVERSAMPLE`-1 and wraps to 0 at each bit boundary. Width is ceil(log2(`OVERSAMPLE`)).
- Bit index: 3 bits, 0..7. It advances only in DATA, at each bit boundary.
- Parity is computed from the latched byte, not from the live `tx_data`.
- `tx_data` may change freely after the accepting edge.
- `tx_start` while `tx_busy`=1 is ignored and not queued.
- `tx_complete_flag` stays 1 until `tx_complete_del_flag` is sampled high, then clears on that edge. A new accepted `tx_start` also clears it.
- If the flag-set edge and `tx_complete_del_flag`=1 coincide, set wins and the flag stays 1.
- `tx_start` and `tx_complete_del_flag` together in IDLE: the frame starts and the flag ends 0.

## Timing
- Let E0 be the edge that samples `tx_start`=1 in IDLE.
- After E0: `TXD`=0 and `tx_busy`=1. No gap cycles between the request and the start bit.
- Data bit k is on `TXD` from edge E0+(k+1)x`OVERSAMPLE`.
- Frame length F = (1+8+`PARITY_EN`+`STOP_BITS`)x`OVERSAMPLE` cycles; default 160.
- At edge E0+F: `tx_busy` 1→0, `tx_complete_flag` 0→1, `TXD` remains 1.
- Back-to-back: `tx_start` held high at edge E0+F+1 starts the next frame. Minimum idle between stop and next start is 1 cycle.
- Each bit on `TXD` lasts exactly `OVERSAMPLE` cycles. No glitches: `TXD` is only ever the output of a flop.

## Test plan
- Default params, `tx_data`=0x55, 1-cycle `tx_start` → `TXD` bits 0,1,0,1,0,1,0,1,0,1, each 16 cycles; `tx_busy` high 160 cycles; flag rises at E0+160.
- `PARITY_EN`=1, `PARITY_ODD`=0, `STOP_BITS`=2, `tx_data`=0xA5 → data 1,0,1,0,0,1,0,1 LSB first, parity 0, two stop bits; frame 192 cycles.
- `tx_data`=0x0F accepted; at E0+50 pulse `tx_start` with 0xFF → frame still carries 0x0F; no second frame after `tx_busy` falls.
- After 0x3C completes → flag stays 1 for 20 idle cycles. Pulse `tx_complete_del_flag` → flag 0 next edge. Del pulse on the set edge → flag remains 1.
- `reset_n` low at E0+70 during 0x81 → `TXD`=1, `tx_busy`=0, flag 0 asynchronously. After release, 0x81 sends a clean full frame.
- Two frames 0x12 then 0x34 with `tx_start` held high → second start bit begins 1 cycle after first frame end. Flag cleared at second accept, set again at second end.
